// File: rtl/cut_sequencer_pkg.sv
// Shared kitchen constants: clock rate, default motor timings and the cut sequencer state encoding.
// The default timings are also used by cut_driver.
package kitchen_pkg;

  localparam int unsigned CLK_HZ             = 50_000_000;
  localparam int unsigned CUT_CNT_W          = 8;
  localparam int unsigned SETTLE_CYCLES_DEF  = 2_500_000;    // 50 ms
  localparam int unsigned FEED_CYCLES_DEF    = 5_000_000;    // 100 ms
  localparam int unsigned TIMEOUT_CYCLES_DEF = 100_000_000;  // 2 s
  localparam int unsigned TIMER_W            = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CUT    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_FEED   = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cut_sequencer_if.sv
// Command interface between the kitchen controller (master) and the cut sequencer (slave).
interface cut_sequencer_if import kitchen_pkg::*; #(
  parameter int unsigned CNT_W = CUT_CNT_W
) ();
  // start_i is a one-cycle request that is only honoured while state is ST_IDLE. The request
  // is not acknowledged. busy_o stays high for the whole job and done_o pulses once at the
  // end. If start_i arrives outside idle, it is dropped. abort_i is a level and overrides
  // everything.
  logic             start_i;
  logic [CNT_W-1:0] num_cuts_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic             error_o;
  logic [CNT_W-1:0] cuts_done_o;
  seq_state_e       state;

  modport master (
    output start_i, num_cuts_i, abort_i,
    input  busy_o, done_o, error_o, cuts_done_o, state
  );

  modport slave (
    input  start_i, num_cuts_i, abort_i,
    output busy_o, done_o, error_o, cuts_done_o, state
  );
endinterface

// File: rtl/cut_sequencer_edge_sync_rise.sv
// Synchronises a slow asynchronous level with two flops and emits a one-cycle registered pulse
// on its rising edge. The pulse appears three clocks after the input rises.
module edge_sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);
  logic sync1, sync2, sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      sync1  <= async_i;
      sync2  <= sync1;
      sync3  <= sync2;
      rise_o <= sync2 & ~sync3;
    end
  end
endmodule

// File: rtl/cut_sequencer.sv
// Job controller for the cutting motor. It runs one stroke at a time, then settles and feeds
// between strokes, and it faults if a stroke never reports completion.
module cut_sequencer import kitchen_pkg::*; #(
  parameter int unsigned CNT_W          = CUT_CNT_W,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned FEED_CYCLES    = FEED_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cut_sequencer_if.slave   cmd,
  output logic             cut_o,
  input  logic             cut_end_i,
  output logic             feed_o
);
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FEED_LAST    = TIMER_W'(FEED_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  seq_state_e       state;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0] n_target;
  logic [CNT_W-1:0] cuts_done;
  logic [CNT_W-1:0] cuts_next;
  logic             busy, done, error;
  logic             end_evt;

  edge_sync_rise u_end_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (cut_end_i),
    .rise_o  (end_evt)
  );

  assign cuts_next = cuts_done + CNT_W'(1);

  // One timer serves every timed state. It restarts on each entry and only runs where a
  // limit is being measured, so it never wraps while idle or faulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      n_target  <= '0;
      cuts_done <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cut_o     <= 1'b0;
      feed_o    <= 1'b0;
    end else if (cmd.abort_i) begin
      state  <= ST_IDLE;
      timer  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      cut_o  <= 1'b0;
      feed_o <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd.start_i) begin
            timer     <= '0;
            cuts_done <= '0;
            if (cmd.num_cuts_i != '0) begin
              n_target <= cmd.num_cuts_i;
              state    <= ST_CUT;
              cut_o    <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_CUT: begin
          timer <= timer + TIMER_W'(1);
          if (end_evt) begin
            cut_o     <= 1'b0;
            cuts_done <= cuts_next;
            timer     <= '0;
            if (cuts_next == n_target) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_SETTLE;
            end
          end else if (timer == TIMEOUT_LAST) begin
            cut_o <= 1'b0;
            busy  <= 1'b0;
            error <= 1'b1;
            timer <= '0;
            state <= ST_FAULT;
          end
        end
        ST_SETTLE: begin
          timer <= timer + TIMER_W'(1);
          if (timer == SETTLE_LAST) begin
            timer  <= '0;
            feed_o <= 1'b1;
            state  <= ST_FEED;
          end
        end
        ST_FEED: begin
          timer <= timer + TIMER_W'(1);
          if (timer == FEED_LAST) begin
            timer  <= '0;
            feed_o <= 1'b0;
            cut_o  <= 1'b1;
            state  <= ST_CUT;
          end
        end
        ST_DONE: begin
          timer <= '0;
          state <= ST_IDLE;
        end
        ST_FAULT: begin
          cut_o  <= 1'b0;
          feed_o <= 1'b0;
          error  <= 1'b1;
        end
        default: begin
          timer <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd.busy_o      = busy;
  assign cmd.done_o      = done;
  assign cmd.error_o     = error;
  assign cmd.cuts_done_o = cuts_done;
  assign cmd.state       = state;
endmodule

// File: tb/tb_cut_sequencer.sv
// Directed bench for cut_sequencer with shortened timings. A behavioural cut_driver answers
// each stroke, and a negedge monitor turns output activity into events for the scoreboard.
module tb_cut_sequencer;
  import kitchen_pkg::*;

  localparam int W = 24;
  localparam logic [7:0] EV_CUT_FALL = 8'd1;
  localparam logic [7:0] EV_GAP      = 8'd2;
  localparam logic [7:0] EV_FEED     = 8'd3;
  localparam logic [7:0] EV_DONE     = 8'd4;
  localparam logic [7:0] EV_ERR      = 8'd5;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic cut_o, feed_o;
  logic cut_end_i = 1'b0;

  cut_sequencer_if #(.CNT_W(8)) cmd ();

  cut_sequencer #(
    .CNT_W          (8),
    .SETTLE_CYCLES  (4),
    .FEED_CYCLES    (6),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .cut_o     (cut_o),
    .cut_end_i (cut_end_i),
    .feed_o    (feed_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  bit model_en = 1'b1;
  int hold_cyc = 5;

  function automatic logic [W-1:0] ev(input logic [7:0] k, input logic [7:0] a,
                                      input logic [7:0] b);
    return {k, a, b};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic sb_pop(input logic [W-1:0] got);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got event %06h expected none", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL sb_event: got event %06h expected %06h", got, e);
      end
    end
  endtask

  // behavioural cut_driver: stroke ends 10 cycles after cut_o rises
  always begin
    @(posedge cut_o);
    if (model_en) begin
      repeat (10) @(negedge clk);
      cut_end_i = 1'b1;
      repeat (hold_cyc) @(negedge clk);
      cut_end_i = 1'b0;
    end
  end

  // monitor
  logic prev_cut = 1'b0, prev_feed = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
  int since_rise = 255, since_fall = 255, feed_w = 0, done_w = 0;

  always @(negedge clk) begin
    if (cut_o && !prev_cut) since_rise = 0;
    else if (since_rise < 255) since_rise++;
    if (!cut_o && prev_cut) since_fall = 0;
    else if (since_fall < 255) since_fall++;
    if (feed_o) feed_w = prev_feed ? feed_w + 1 : 1;
    if (cmd.done_o) done_w = prev_done ? done_w + 1 : 1;

    if (prev_cut && !cut_o)          sb_pop(ev(EV_CUT_FALL, 8'd0, cmd.cuts_done_o));
    if (cmd.error_o && !prev_err)    sb_pop(ev(EV_ERR, 8'(since_rise), {7'd0, cut_o}));
    if (feed_o && !prev_feed)        sb_pop(ev(EV_GAP, 8'(since_fall), 8'd0));
    if (!feed_o && prev_feed)        sb_pop(ev(EV_FEED, 8'(feed_w), 8'd0));
    if (!cmd.done_o && prev_done)    sb_pop(ev(EV_DONE, 8'(done_w), cmd.cuts_done_o));

    prev_cut  = (cut_o === 1'b1);
    prev_feed = (feed_o === 1'b1);
    prev_done = (cmd.done_o === 1'b1);
    prev_err  = (cmd.error_o === 1'b1);
  end

  // driver tasks
  task automatic issue(input logic [7:0] n);
    @(negedge clk);
    cmd.start_i    = 1'b1;
    cmd.num_cuts_i = n;
    @(negedge clk);
    cmd.start_i    = 1'b0;
    cmd.num_cuts_i = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd.state == ST_IDLE && !cmd.busy_o) break;
      @(negedge clk);
    end
    check(name, cmd.state, ST_IDLE);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_stroke_feed(input logic [7:0] cuts);
    exp_q.push_back(ev(EV_CUT_FALL, 8'd0, cuts));
    exp_q.push_back(ev(EV_GAP, 8'd4, 8'd0));
    exp_q.push_back(ev(EV_FEED, 8'd6, 8'd0));
  endtask

  task automatic run_single();
    exp_q.push_back(ev(EV_CUT_FALL, 8'd0, 8'd1));
    exp_q.push_back(ev(EV_DONE, 8'd1, 8'd1));
    issue(8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    cmd.start_i    = 1'b0;
    cmd.num_cuts_i = '0;
    cmd.abort_i    = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_state", cmd.state, ST_IDLE);
    check("rst_busy", cmd.busy_o, 0);
    check("rst_done", cmd.done_o, 0);
    check("rst_error", cmd.error_o, 0);
    check("rst_cuts", cmd.cuts_done_o, 0);
    check("rst_cut_feed", {cut_o, feed_o}, 0);

    // three-slice job
    push_stroke_feed(8'd1);
    push_stroke_feed(8'd2);
    exp_q.push_back(ev(EV_CUT_FALL, 8'd0, 8'd3));
    exp_q.push_back(ev(EV_DONE, 8'd1, 8'd3));
    issue(8'd3);
    wait_idle("n3_idle", 300);
    check("n3_busy_after", cmd.busy_o, 0);
    check("n3_cuts", cmd.cuts_done_o, 3);
    check("n3_drain", exp_q.size(), 0);

    // zero-slice job
    exp_q.push_back(ev(EV_DONE, 8'd1, 8'd0));
    issue(8'd0);
    check("n0_done_timing", cmd.done_o, 1);
    @(negedge clk);
    check("n0_done_pulse", cmd.done_o, 0);
    wait_idle("n0_idle", 20);
    check("n0_cuts", cmd.cuts_done_o, 0);
    check("n0_drain", exp_q.size(), 0);

    // stroke timeout
    model_en = 1'b0;
    exp_q.push_back(ev(EV_CUT_FALL, 8'd0, 8'd0));
    exp_q.push_back(ev(EV_ERR, 8'd50, 8'd0));
    issue(8'd2);
    for (int i = 0; i < 100 && !cmd.error_o; i++) @(negedge clk);
    check("to_error", cmd.error_o, 1);
    check("to_cut_low", cut_o, 0);
    issue(8'd1);
    repeat (3) @(negedge clk);
    check("to_start_ignored", cmd.state, ST_FAULT);
    check("to_error_held", {cmd.error_o, cut_o, cmd.busy_o}, 3'b100);
    cmd.abort_i = 1'b1;
    @(negedge clk);
    cmd.abort_i = 1'b0;
    check("to_abort_error", cmd.error_o, 0);
    check("to_abort_state", cmd.state, ST_IDLE);
    check("to_drain", exp_q.size(), 0);
    model_en = 1'b1;

    // abort during feed
    exp_q.push_back(ev(EV_CUT_FALL, 8'd0, 8'd1));
    exp_q.push_back(ev(EV_GAP, 8'd4, 8'd0));
    exp_q.push_back(ev(EV_FEED, 8'd3, 8'd0));
    issue(8'd4);
    for (int i = 0; i < 100 && !feed_o; i++) @(negedge clk);
    check("ab_feed_seen", feed_o, 1);
    repeat (2) @(negedge clk);
    cmd.abort_i = 1'b1;
    @(negedge clk);
    cmd.abort_i = 1'b0;
    check("ab_feed_low", feed_o, 0);
    check("ab_busy", cmd.busy_o, 0);
    check("ab_cuts_held", cmd.cuts_done_o, 1);
    repeat (4) @(negedge clk);
    check("ab_no_done_drain", exp_q.size(), 0);
    run_single();
    wait_idle("ab_restart_idle", 100);
    check("ab_restart_drain", exp_q.size(), 0);

    // long cut_end and glitch outside CUT
    hold_cyc = 40;
    run_single();
    wait_idle("hold_idle", 100);
    repeat (45) @(negedge clk);
    check("hold_cuts", cmd.cuts_done_o, 1);
    cut_end_i = 1'b1;
    repeat (2) @(negedge clk);
    cut_end_i = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_cuts", cmd.cuts_done_o, 1);
    check("glitch_state", {cmd.state, cmd.busy_o}, {ST_IDLE, 1'b0});
    check("hold_drain", exp_q.size(), 0);
    hold_cyc = 5;

    // reset in the middle of the second stroke
    push_stroke_feed(8'd1);
    exp_q.push_back(ev(EV_CUT_FALL, 8'd0, 8'd0));
    issue(8'd3);
    for (int i = 0; i < 200 && !(cut_o && cmd.cuts_done_o == 8'd1); i++) @(negedge clk);
    check("rstmid_second_stroke", {cut_o, cmd.cuts_done_o}, {1'b1, 8'd1});
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_cut", cut_o, 0);
    check("rstmid_busy", cmd.busy_o, 0);
    check("rstmid_cuts", cmd.cuts_done_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("rstmid_drain", exp_q.size(), 0);
    run_single();
    wait_idle("rstmid_restart_idle", 100);
    check("final_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
